// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: credit/purchase controller for the vending machine.
// Accepts one-hot coin pulses, vends products from a packed price table,
// pays change back one coin per cycle, and drives the display mode with
// a timed hold after each vend or rejected purchase.
module vend_credit_ctrl #(
  parameter int                              CREDIT_W     = 8,
  parameter int                              NUM_PRODUCTS = 4,
  parameter int                              PRODUCT_W    = 2,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES      = {8'd40, 8'd30, 8'd20, 8'd75},
  parameter int                              HOLD_CYCLES  = 6,
  parameter bit                              AUTO_CHANGE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           coin,
  input  logic                 buy,
  input  logic [PRODUCT_W-1:0] product,
  input  logic                 refund,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 dispense,
  output logic [PRODUCT_W-1:0] dispense_id,
  output logic                 error,
  output logic                 overflow,
  output logic [3:0]           change_coin,
  output logic                 busy,
  output logic [1:0]           disp_mode,
  output logic [PRODUCT_W-1:0] disp_id
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_CHANGE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DISP_CREDIT  = 2'd0,
    DISP_PRODUCT = 2'd1,
    DISP_ERROR   = 2'd2
  } disp_mode_e;

  // Registered state and outputs
  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic                 dispense_q, dispense_d;
  logic [PRODUCT_W-1:0] dispense_id_q, dispense_id_d;
  logic                 error_q, error_d;
  logic                 overflow_q, overflow_d;
  logic [3:0]           change_coin_q, change_coin_d;
  logic                 busy_q, busy_d;
  disp_mode_e           disp_mode_q, disp_mode_d;
  logic [PRODUCT_W-1:0] disp_id_q, disp_id_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  // Combinational helpers
  logic [CREDIT_W-1:0]  coin_val;
  logic [CREDIT_W-1:0]  price;
  logic                 product_ok;
  logic [3:0]           chg_onehot;
  logic [CREDIT_W-1:0]  chg_val;
  logic [CREDIT_W-1:0]  debit;
  logic [CREDIT_W:0]    sum;

  // Coin value decode; anything not exactly one-hot is worth nothing.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated value; only the clocked block uses '<='.
  always_comb begin
    case (coin)
      4'b0001: coin_val = CREDIT_W'(1);
      4'b0010: coin_val = CREDIT_W'(5);
      4'b0100: coin_val = CREDIT_W'(10);
      4'b1000: coin_val = CREDIT_W'(25);
      default: coin_val = '0;
    endcase
  end

  // Price table lookup; codes beyond the table are flagged as invalid.
  always_comb begin
    price      = '0;
    product_ok = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (product == PRODUCT_W'(i)) begin
        price      = PRICES[i*CREDIT_W +: CREDIT_W];
        product_ok = 1'b1;
      end
    end
  end

  // Largest change coin that does not exceed the current credit.
  always_comb begin
    if (credit_q >= CREDIT_W'(25)) begin
      chg_onehot = 4'b1000;
      chg_val    = CREDIT_W'(25);
    end else if (credit_q >= CREDIT_W'(10)) begin
      chg_onehot = 4'b0100;
      chg_val    = CREDIT_W'(10);
    end else if (credit_q >= CREDIT_W'(5)) begin
      chg_onehot = 4'b0010;
      chg_val    = CREDIT_W'(5);
    end else if (credit_q != '0) begin
      chg_onehot = 4'b0001;
      chg_val    = CREDIT_W'(1);
    end else begin
      chg_onehot = 4'b0000;
      chg_val    = '0;
    end
  end

  // Next-state logic: purchase/refund FSM, saturating credit, display hold.
  // NOTE: every signal assigned here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    debit         = '0;
    dispense_d    = 1'b0;
    dispense_id_d = '0;
    error_d       = 1'b0;
    overflow_d    = 1'b0;
    change_coin_d = 4'b0000;
    disp_mode_d   = disp_mode_q;
    disp_id_d     = disp_id_q;
    hold_d        = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (buy) begin
          // Compare against credit before this cycle's coin.
          if (product_ok && (credit_q >= price)) begin
            debit         = price;
            dispense_d    = 1'b1;
            dispense_id_d = product;
          end else begin
            error_d = 1'b1;
          end
        end else if (refund && (credit_q != '0)) begin
          state_d = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        // Buy and refund are ignored while paying out.
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          change_coin_d = chg_onehot;
          debit         = chg_val;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Debit never exceeds credit, so only the upper bound needs clamping.
    sum = {1'b0, credit_q} - {1'b0, debit} + {1'b0, coin_val};
    if (sum[CREDIT_W]) begin
      credit_d   = '1;
      overflow_d = 1'b1;
    end else begin
      credit_d   = sum[CREDIT_W-1:0];
    end

    if (AUTO_CHANGE && dispense_d && (credit_d != '0)) begin
      state_d = ST_CHANGE;
    end

    busy_d = (state_d != ST_IDLE);

    if (dispense_d) begin
      disp_mode_d = DISP_PRODUCT;
      disp_id_d   = product;
      hold_d      = HOLD_W'(HOLD_CYCLES);
    end else if (error_d) begin
      disp_mode_d = DISP_ERROR;
      hold_d      = HOLD_W'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
      if (hold_q == HOLD_W'(1)) begin
        disp_mode_d = DISP_CREDIT;
      end
    end
  end

  // State and output registers with synchronous reset.
  // NOTE: reset is sampled on the clock edge only, so it is tested inside
  // the posedge block and overrides every other input that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      dispense_q    <= 1'b0;
      dispense_id_q <= '0;
      error_q       <= 1'b0;
      overflow_q    <= 1'b0;
      change_coin_q <= 4'b0000;
      busy_q        <= 1'b0;
      disp_mode_q   <= DISP_CREDIT;
      disp_id_q     <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      dispense_q    <= dispense_d;
      dispense_id_q <= dispense_id_d;
      error_q       <= error_d;
      overflow_q    <= overflow_d;
      change_coin_q <= change_coin_d;
      busy_q        <= busy_d;
      disp_mode_q   <= disp_mode_d;
      disp_id_q     <= disp_id_d;
      hold_q        <= hold_d;
    end
  end

  assign credit      = credit_q;
  assign dispense    = dispense_q;
  assign dispense_id = dispense_id_q;
  assign error       = error_q;
  assign overflow    = overflow_q;
  assign change_coin = change_coin_q;
  assign busy        = busy_q;
  assign disp_mode   = disp_mode_q;
  assign disp_id     = disp_id_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Testbench for vend_credit_ctrl. Two instances share one stimulus stream:
// dut_a uses the default configuration, dut_b has a 3-bit product code (so
// codes 4..7 are out of range) and automatic change after a vend.
// The driver pushes the reference model's expected outputs into queues and
// a separate monitor pops and compares them after every clock edge.
module tb_vend_credit_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] coin;
  logic       buy;
  logic [2:0] product;
  logic       refund;

  logic [7:0] credit_a, credit_b;
  logic       dispense_a, dispense_b;
  logic [1:0] dispense_id_a;
  logic [2:0] dispense_id_b;
  logic       error_a, error_b;
  logic       overflow_a, overflow_b;
  logic [3:0] change_coin_a, change_coin_b;
  logic       busy_a, busy_b;
  logic [1:0] disp_mode_a, disp_mode_b;
  logic [1:0] disp_id_a;
  logic [2:0] disp_id_b;

  vend_credit_ctrl dut_a (
    .clk(clk), .reset(reset), .coin(coin), .buy(buy), .product(product[1:0]),
    .refund(refund), .credit(credit_a), .dispense(dispense_a),
    .dispense_id(dispense_id_a), .error(error_a), .overflow(overflow_a),
    .change_coin(change_coin_a), .busy(busy_a), .disp_mode(disp_mode_a),
    .disp_id(disp_id_a)
  );

  vend_credit_ctrl #(.PRODUCT_W(3), .AUTO_CHANGE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .coin(coin), .buy(buy), .product(product),
    .refund(refund), .credit(credit_b), .dispense(dispense_b),
    .dispense_id(dispense_id_b), .error(error_b), .overflow(overflow_b),
    .change_coin(change_coin_b), .busy(busy_b), .disp_mode(disp_mode_b),
    .disp_id(disp_id_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- model
  // Coin values by one-hot bit position, and the price of each product
  // (product 0 sits in the LSBs of the packed table, so it costs 75).
  int coin_tbl  [4] = '{1, 5, 10, 25};
  int price_tbl [4] = '{75, 20, 30, 40};

  typedef struct {
    int credit;
    bit paying;
    int hold;
    int mode;
    int id;
  } mst_t;

  typedef struct {
    int         credit;
    bit         dispense;
    int         did;
    bit         error;
    bit         ovf;
    logic [3:0] chg;
    bit         busy;
    int         mode;
    int         id;
  } exp_t;

  mst_t ms_a, ms_b;
  exp_t exp_a_q[$];
  exp_t exp_b_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit auto_chg, input mst_t si,
                                     input bit rst, input logic [3:0] c,
                                     input bit b, input int p, input bit r,
                                     output mst_t so, output exp_t e);
    int cv;
    int debit;
    int total;
    bit found;
    e  = '{default: 0};
    so = si;
    if (rst) begin
      so = '{default: 0};
      return;
    end
    cv = 0;
    if ($countones(c) == 1)
      for (int i = 0; i < 4; i++) if (c[i]) cv = coin_tbl[i];
    debit = 0;
    if (!si.paying) begin
      if (b) begin
        if (p < 4 && si.credit >= price_tbl[p]) begin
          e.dispense = 1'b1;
          e.did      = p;
          debit      = price_tbl[p];
        end else begin
          e.error = 1'b1;
        end
      end else if (r && si.credit > 0) begin
        so.paying = 1'b1;
      end
    end else if (si.credit == 0) begin
      so.paying = 1'b0;
    end else begin
      found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
        if (!found && coin_tbl[i] <= si.credit) begin
          found = 1'b1;
          debit = coin_tbl[i];
          e.chg = 4'b0001 << i;
        end
      end
    end
    total = si.credit - debit + cv;
    if (total > 255) begin
      total = 255;
      e.ovf = 1'b1;
    end
    if (auto_chg && e.dispense && total > 0) so.paying = 1'b1;
    if (e.dispense) begin
      so.mode = 1; so.id = p; so.hold = 6;
    end else if (e.error) begin
      so.mode = 2; so.hold = 6;
    end else if (si.hold > 0) begin
      so.hold = si.hold - 1;
      if (so.hold == 0) so.mode = 0;
    end
    so.credit = total;
    e.credit  = total;
    e.busy    = so.paying;
    e.mode    = so.mode;
    e.id      = so.id;
  endfunction

  // --------------------------------------------------------------- driver
  // One call = one clock cycle. Inputs change on the falling edge; the task
  // returns shortly after the rising edge so directed checks see new outputs.
  task automatic step(input bit rst, input logic [3:0] c, input bit b,
                      input logic [2:0] p, input bit r);
    mst_t na, nb;
    exp_t ea, eb;
    @(negedge clk);
    reset = rst; coin = c; buy = b; product = p; refund = r;
    model_step(1'b0, ms_a, rst, c, b, int'(p[1:0]), r, na, ea);
    model_step(1'b1, ms_b, rst, c, b, int'(p), r, nb, eb);
    ms_a = na;
    ms_b = nb;
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic put_coin(input logic [3:0] c);
    step(1'b0, c, 1'b0, 3'd0, 1'b0);
  endtask

  // Let any payout finish, bounded; a stuck FSM shows up as a failed check.
  task automatic drain();
    for (int i = 0; i < 40 && (busy_a || busy_b); i++) idle();
    check("drain_busy", int'(busy_a | busy_b), 0);
  endtask

  // -------------------------------------------------------------- monitor
  // Outputs are presented every cycle; compare each against the queue head.
  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a_q.size() > 0 && exp_b_q.size() > 0) begin
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        check("a_credit",    int'(credit_a),      ea.credit);
        check("a_dispense",  int'(dispense_a),    int'(ea.dispense));
        if (ea.dispense) check("a_dispense_id", int'(dispense_id_a), ea.did);
        check("a_error",     int'(error_a),       int'(ea.error));
        check("a_overflow",  int'(overflow_a),    int'(ea.ovf));
        check("a_change",    int'(change_coin_a), int'(ea.chg));
        check("a_busy",      int'(busy_a),        int'(ea.busy));
        check("a_disp_mode", int'(disp_mode_a),   ea.mode);
        check("a_disp_id",   int'(disp_id_a),     ea.id);
        check("b_credit",    int'(credit_b),      eb.credit);
        check("b_dispense",  int'(dispense_b),    int'(eb.dispense));
        if (eb.dispense) check("b_dispense_id", int'(dispense_id_b), eb.did);
        check("b_error",     int'(error_b),       int'(eb.error));
        check("b_overflow",  int'(overflow_b),    int'(eb.ovf));
        check("b_change",    int'(change_coin_b), int'(eb.chg));
        check("b_busy",      int'(busy_b),        int'(eb.busy));
        check("b_disp_mode", int'(disp_mode_b),   eb.mode);
        check("b_disp_id",   int'(disp_id_b),     eb.id);
      end
    end
  end

  // Global time bound so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    int         hold_len;
    logic [3:0] seq [4];
    logic [3:0] rc;
    int         sel;

    reset = 1'b1; coin = 4'b0000; buy = 1'b0; product = 3'd0; refund = 1'b0;
    ms_a = '{default: 0};
    ms_b = '{default: 0};
    seq[0] = 4'b1000; seq[1] = 4'b0100; seq[2] = 4'b0010; seq[3] = 4'b0001;

    step(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);
    check("rst_credit", int'(credit_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_disp_mode", int'(disp_mode_a), 0);

    // Three quarters then buy product 0 (75c); display held 6 cycles.
    repeat (3) put_coin(4'b1000);
    check("q3_credit", int'(credit_a), 75);
    step(1'b0, 4'b0000, 1'b1, 3'd0, 1'b0);
    check("vend0_dispense", int'(dispense_a), 1);
    check("vend0_id", int'(dispense_id_a), 0);
    check("vend0_credit", int'(credit_a), 0);
    check("vend0_disp_mode", int'(disp_mode_a), 1);
    hold_len = 1;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (disp_mode_a == 2'd1) hold_len++;
    end
    check("hold_len", hold_len, 6);

    // Credit 15, product 3 (40c) is rejected; a quarter with the buy still errors.
    put_coin(4'b0100);
    put_coin(4'b0010);
    step(1'b0, 4'b0000, 1'b1, 3'd3, 1'b0);
    check("rej_error", int'(error_a), 1);
    check("rej_credit", int'(credit_a), 15);
    check("rej_disp_mode", int'(disp_mode_a), 2);
    step(1'b0, 4'b1000, 1'b1, 3'd3, 1'b0);
    check("rej_coin_credit", int'(credit_a), 40);
    check("rej_coin_error", int'(error_a), 1);
    step(1'b0, 4'b0000, 1'b1, 3'd3, 1'b0);
    check("vend3_dispense", int'(dispense_a), 1);
    check("vend3_credit", int'(credit_a), 0);

    // Saturation at 255 and a multi-hot coin being ignored.
    repeat (10) put_coin(4'b1000);
    check("q10_credit", int'(credit_a), 250);
    put_coin(4'b1000);
    check("sat_credit", int'(credit_a), 255);
    check("sat_overflow", int'(overflow_a), 1);
    put_coin(4'b0110);
    check("multihot_credit", int'(credit_a), 255);
    check("multihot_overflow", int'(overflow_a), 0);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    drain();

    // Credit 41 refunded as 25,10,5,1; busy drops the cycle after.
    put_coin(4'b1000); put_coin(4'b0100); put_coin(4'b0010); put_coin(4'b0001);
    check("c41_credit", int'(credit_a), 41);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    check("refund_busy", int'(busy_a), 1);
    check("refund_no_coin_yet", int'(change_coin_a), 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("chg_seq", int'(change_coin_a), int'(seq[i]));
    end
    idle();
    check("chg_done_busy", int'(busy_a), 0);
    check("chg_done_coin", int'(change_coin_a), 0);
    check("chg_done_credit", int'(credit_a), 0);

    // 50c, buy product 2 (30c): dut_b pays 10,10 automatically.
    put_coin(4'b1000); put_coin(4'b1000);
    step(1'b0, 4'b0000, 1'b1, 3'd2, 1'b0);
    check("auto_dispense", int'(dispense_b), 1);
    check("auto_credit", int'(credit_b), 20);
    check("auto_busy", int'(busy_b), 1);
    check("manual_busy", int'(busy_a), 0);
    idle();
    check("auto_chg1", int'(change_coin_b), 4);
    idle();
    check("auto_chg2", int'(change_coin_b), 4);
    check("auto_credit_end", int'(credit_b), 0);
    idle();
    check("auto_busy_end", int'(busy_b), 0);

    // dut_a holds 20c: buy product 1 (20c) together with refund.
    step(1'b0, 4'b0000, 1'b1, 3'd1, 1'b1);
    check("buyref_dispense", int'(dispense_a), 1);
    check("buyref_credit", int'(credit_a), 0);
    check("buyref_busy", int'(busy_a), 0);
    check("buyref_b_error", int'(error_b), 1);
    idle();
    check("buyref_busy_later", int'(busy_a), 0);

    // Out-of-range product code on dut_b.
    repeat (4) put_coin(4'b1000);
    step(1'b0, 4'b0000, 1'b1, 3'd5, 1'b0);
    check("oor_error", int'(error_b), 1);
    check("oor_dispense", int'(dispense_b), 0);
    check("oor_credit", int'(credit_b), 100);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    drain();

    // Reset while paying out 37c.
    put_coin(4'b1000); put_coin(4'b0100); put_coin(4'b0001); put_coin(4'b0001);
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    check("pre_rst_busy", int'(busy_a), 1);
    check("pre_rst_credit", int'(credit_a), 37);
    step(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);
    check("mid_rst_credit", int'(credit_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_change", int'(change_coin_a), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      rc = 4'b0000;
      else if (sel < 9) rc = 4'b0001 << $urandom_range(0, 3);
      else              rc = 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, rc, $urandom_range(0, 9) == 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    end
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    drain();
    idle();
    idle();
    @(posedge clk);
    #3;
    check("scoreboard_empty", exp_a_q.size() + exp_b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
